// File: rtl/inst_fetch_queue_if.sv
// ============================================================================
//  Module   : inst_fetch_queue_if
//  Purpose  : Run control, instruction-memory and CPU-decode signals of the
//             instruction fetch queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_fetch_queue_if;
    logic        enable;
    logic        start;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic [7:0]  imem_addr;
    logic        imem_re;
    logic [15:0] imem_data;
    logic [15:0] i_datain;
    logic        i_valid;
    logic        i_ready;
    logic        halted;

    // master is the fetch queue itself, slave is its environment
    modport master (
        input  enable, start, redirect, redirect_addr, imem_data, i_ready,
        output imem_addr, imem_re, i_datain, i_valid, halted
    );

    modport slave (
        output enable, start, redirect, redirect_addr, imem_data, i_ready,
        input  imem_addr, imem_re, i_datain, i_valid, halted
    );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
//  Module   : inst_fetch_queue
//  Purpose  : Sequential instruction prefetcher feeding a 4-entry FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
    parameter logic [4:0]  HALT_OP  = 5'b00001,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic               clock,
    input  logic               reset,
    inst_fetch_queue_if.master bus
);

    localparam int         DEPTH     = 4;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]  state_q,    state_d;
    logic [7:0]  fetch_pc_q, fetch_pc_d;
    logic [2:0]  count_q,    count_d;
    logic [1:0]  rd_ptr_q,   rd_ptr_d;
    logic [1:0]  wr_ptr_q,   wr_ptr_d;
    logic        inflight_q, inflight_d;
    logic [15:0] fifo_q [DEPTH];
    logic [15:0] fifo_d [DEPTH];

    logic [2:0]  w_occupancy;
    logic        w_flush;
    logic        w_issue;
    logic        w_push;
    logic        w_pop;
    logic        w_push_halt;

    // Slots already promised to an outstanding read count against capacity
    assign w_occupancy = count_q + {2'b00, inflight_q};
    assign w_flush     = bus.enable & bus.redirect & (state_q != ST_IDLE);
    assign w_issue     = (state_q == ST_FETCH) & bus.enable & ~bus.redirect
                         & (w_occupancy < 3'd4);
    assign w_push      = inflight_q & ~w_flush;
    assign w_pop       = (count_q != 3'd0) & bus.i_ready & bus.enable & ~w_flush;
    assign w_push_halt = w_push & (bus.imem_data[15:11] == HALT_OP);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = inflight_q;
        fifo_d     = fifo_q;

        if (w_flush) begin
            state_d    = ST_FETCH;
            fetch_pc_d = bus.redirect_addr;
            count_d    = 3'd0;
            rd_ptr_d   = 2'd0;
            wr_ptr_d   = 2'd0;
            inflight_d = 1'b0;
        end else begin
            // A read issued alongside the HALT push is dropped by never arming it
            inflight_d = w_issue & ~w_push_halt;
            if (w_issue) begin
                fetch_pc_d = fetch_pc_q + 8'd1;
            end
            if (w_push) begin
                fifo_d[wr_ptr_q] = bus.imem_data;
                wr_ptr_d         = wr_ptr_q + 2'd1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase

            case (state_q)
                ST_IDLE: begin
                    if (bus.start && bus.enable) begin
                        state_d    = ST_FETCH;
                        fetch_pc_d = 8'h00;
                    end
                end
                ST_FETCH: begin
                    if (w_push_halt) begin
                        state_d = ST_HALTED;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= 8'h00;
            count_q    <= 3'd0;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            inflight_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= 16'h0000;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
        end
    end

    assign bus.imem_re   = w_issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.i_valid   = (count_q != 3'd0);
    assign bus.i_datain  = (count_q != 3'd0) ? fifo_q[rd_ptr_q] : NOP_WORD;
    assign bus.halted    = (state_q == ST_HALTED) && (count_q == 3'd0);

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
//  Module   : tb_inst_fetch_queue
//  Purpose  : Directed self-checking bench for inst_fetch_queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;

    logic        clock;
    logic        reset;
    logic        log_clr;
    logic [15:0] mem [256];
    logic [15:0] mem_rdata;
    logic [7:0]  req_cnt;
    logic [7:0]  max_addr;
    int          checks;
    int          errors;

    inst_fetch_queue_if bus ();

    inst_fetch_queue #(
        .HALT_OP  (5'b00001),
        .NOP_WORD (16'h0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-cycle-latency instruction memory
    always @(posedge clock) begin
        if (bus.imem_re) mem_rdata <= mem[bus.imem_addr];
    end
    assign bus.imem_data = mem_rdata;

    // Request log: count of issued reads and highest address seen
    always @(posedge clock) begin
        if (log_clr) begin
            req_cnt  <= 8'd0;
            max_addr <= 8'd0;
        end else if (bus.imem_re) begin
            req_cnt <= req_cnt + 8'd1;
            if (bus.imem_addr > max_addr) max_addr <= bus.imem_addr;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b1;
        log_clr           = 1'b1;
        mem_rdata         = 16'h0000;
        bus.enable        = 1'b0;
        bus.start         = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 8'h00;
        bus.i_ready       = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = {8'h50, 8'(i)};
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'h0800;

        // Reset values
        tick(); tick();
        check("rst_re",    {15'd0, bus.imem_re}, 16'h0000);
        check("rst_addr",  {8'd0, bus.imem_addr}, 16'h0000);
        check("rst_valid", {15'd0, bus.i_valid}, 16'h0000);
        check("rst_data",  bus.i_datain, 16'h0000);
        check("rst_halt",  {15'd0, bus.halted}, 16'h0000);

        // IDLE: no requests, redirect ignored
        reset      = 1'b0;
        bus.enable = 1'b1;
        tick(); tick();
        check("idle_re", {15'd0, bus.imem_re}, 16'h0000);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 8'h40;
        #1;
        check("idle_redir_re", {15'd0, bus.imem_re}, 16'h0000);
        tick();
        bus.redirect = 1'b0;
        #1;
        check("idle_redir_re2",   {15'd0, bus.imem_re}, 16'h0000);
        check("idle_redir_addr",  {8'd0, bus.imem_addr}, 16'h0000);

        // Full run to HALT with i_ready held high
        bus.i_ready = 1'b1;
        bus.start   = 1'b1;
        log_clr     = 1'b1;
        tick();
        bus.start = 1'b0;
        log_clr   = 1'b0;
        #1;
        check("run_c1_re",    {15'd0, bus.imem_re}, 16'h0001);
        check("run_c1_addr",  {8'd0, bus.imem_addr}, 16'h0000);
        check("run_c1_valid", {15'd0, bus.i_valid}, 16'h0000);
        tick();
        check("run_c2_valid", {15'd0, bus.i_valid}, 16'h0000);
        check("run_c2_addr",  {8'd0, bus.imem_addr}, 16'h0001);
        tick();
        check("run_c3_valid", {15'd0, bus.i_valid}, 16'h0001);
        check("run_c3_data",  bus.i_datain, 16'h1111);
        tick();
        check("run_c4_data",  bus.i_datain, 16'h2222);
        tick();
        check("run_c5_data",  bus.i_datain, 16'h3333);
        check("run_c5_halt",  {15'd0, bus.halted}, 16'h0000);
        tick();
        check("run_c6_data",  bus.i_datain, 16'h0800);
        check("run_c6_re",    {15'd0, bus.imem_re}, 16'h0000);
        check("run_c6_halt",  {15'd0, bus.halted}, 16'h0000);
        tick();
        check("run_c7_valid", {15'd0, bus.i_valid}, 16'h0000);
        check("run_c7_data",  bus.i_datain, 16'h0000);
        check("run_c7_halt",  {15'd0, bus.halted}, 16'h0001);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        check("halt_start_re",   {15'd0, bus.imem_re}, 16'h0000);
        check("halt_start_halt", {15'd0, bus.halted}, 16'h0001);
        tick();
        check("run_req_cnt",  {8'd0, req_cnt}, 16'h0005);
        check("run_max_addr", {8'd0, max_addr}, 16'h0004);

        // Backpressure: queue fills to 4 and issue stops
        mem[3] = 16'h4444;
        do_reset();
        bus.i_ready = 1'b0;
        bus.start   = 1'b1;
        log_clr     = 1'b1;
        tick();
        bus.start = 1'b0;
        log_clr   = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("full_valid", {15'd0, bus.i_valid}, 16'h0001);
        check("full_data",  bus.i_datain, 16'h1111);
        check("full_re",    {15'd0, bus.imem_re}, 16'h0000);
        tick(); tick(); tick();
        check("full_re2",     {15'd0, bus.imem_re}, 16'h0000);
        check("full_req_cnt", {8'd0, req_cnt}, 16'h0004);
        bus.i_ready = 1'b1;
        #1;
        check("full_ready_re", {15'd0, bus.imem_re}, 16'h0000);
        tick();
        check("resume_data", bus.i_datain, 16'h2222);
        check("resume_re",   {15'd0, bus.imem_re}, 16'h0001);
        check("resume_addr", {8'd0, bus.imem_addr}, 16'h0004);

        // Redirect while three entries are queued
        do_reset();
        bus.i_ready = 1'b0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick(); tick();
        check("redir_pre_data", bus.i_datain, 16'h1111);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 8'h40;
        #1;
        check("redir_cyc_re", {15'd0, bus.imem_re}, 16'h0000);
        tick();
        bus.redirect = 1'b0;
        #1;
        check("redir_valid", {15'd0, bus.i_valid}, 16'h0000);
        check("redir_re",    {15'd0, bus.imem_re}, 16'h0001);
        check("redir_addr",  {8'd0, bus.imem_addr}, 16'h0040);
        tick();
        check("redir_valid2", {15'd0, bus.i_valid}, 16'h0000);
        check("redir_addr2",  {8'd0, bus.imem_addr}, 16'h0041);
        tick();
        check("redir_valid3", {15'd0, bus.i_valid}, 16'h0001);
        check("redir_data3",  bus.i_datain, 16'h5040);
        bus.i_ready = 1'b1;
        tick();
        check("redir_data4", bus.i_datain, 16'h5041);

        // Address wrap after redirect to FE
        bus.redirect      = 1'b1;
        bus.redirect_addr = 8'hFE;
        tick();
        bus.redirect = 1'b0;
        #1;
        check("wrap_re_fe",   {15'd0, bus.imem_re}, 16'h0001);
        check("wrap_addr_fe", {8'd0, bus.imem_addr}, 16'h00FE);
        tick();
        check("wrap_addr_ff", {8'd0, bus.imem_addr}, 16'h00FF);
        tick();
        check("wrap_addr_00", {8'd0, bus.imem_addr}, 16'h0000);
        check("wrap_data_fe", bus.i_datain, 16'h50FE);
        tick();
        check("wrap_addr_01", {8'd0, bus.imem_addr}, 16'h0001);
        check("wrap_data_ff", bus.i_datain, 16'h50FF);

        // Freeze for three cycles with a response in flight
        tick();
        bus.enable = 1'b0;
        #1;
        check("frz_re1",   {15'd0, bus.imem_re}, 16'h0000);
        check("frz_data1", bus.i_datain, 16'h1111);
        tick();
        check("frz_re2",   {15'd0, bus.imem_re}, 16'h0000);
        check("frz_data2", bus.i_datain, 16'h1111);
        tick();
        check("frz_data3", bus.i_datain, 16'h1111);
        tick();
        bus.enable = 1'b1;
        #1;
        check("thaw_re",   {15'd0, bus.imem_re}, 16'h0001);
        check("thaw_addr", {8'd0, bus.imem_addr}, 16'h0002);
        check("thaw_data", bus.i_datain, 16'h1111);
        tick();
        check("thaw_data2", bus.i_datain, 16'h2222);
        tick();
        check("thaw_data3", bus.i_datain, 16'h3333);

        // Asynchronous reset mid-fetch with two queued entries
        do_reset();
        bus.i_ready = 1'b0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        check("arst_pre_data", bus.i_datain, 16'h1111);
        reset = 1'b1;
        #1;
        check("arst_re",    {15'd0, bus.imem_re}, 16'h0000);
        check("arst_addr",  {8'd0, bus.imem_addr}, 16'h0000);
        check("arst_valid", {15'd0, bus.i_valid}, 16'h0000);
        check("arst_data",  bus.i_datain, 16'h0000);
        check("arst_halt",  {15'd0, bus.halted}, 16'h0000);
        tick();
        reset   = 1'b0;
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
        tick(); tick(); tick(); tick();
        check("arst_req_cnt", {8'd0, req_cnt}, 16'h0000);
        check("arst_valid2",  {15'd0, bus.i_valid}, 16'h0000);
        check("arst_re2",     {15'd0, bus.imem_re}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter HALT_OP, default 5'b00001, opcode field [15:11] that ends fetching.
REQ-002 Parameter NOP_WORD, default 16'h0000, word driven on i_datain when no instruction is valid.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 enable  in  1  global run; 0 freezes the block.
REQ-006 start  in  1  one-cycle pulse that begins fetching at address 8'h00.
REQ-007 redirect  in  1  branch/jump taken; flushes the queue.
REQ-008 redirect_addr  in  8  new fetch address, valid with redirect.
REQ-009 imem_addr  out  8  instruction memory read address.
REQ-010 imem_re  out  1  read request; memory returns data exactly 1 cycle later.
REQ-011 imem_data  in  16  memory read data.
REQ-012 i_datain  out  16  instruction to CPU decode (head of queue, else NOP_WORD).
REQ-013 i_valid  out  1  i_datain holds a real instruction.
REQ-014 i_ready  in  1  CPU accepts head; a pop occurs on i_valid & i_ready & enable.
REQ-015 halted  out  1  HALT seen and queue empty.

Function
REQ-016 States: IDLE, FETCH, HALTED; encoding is free.
REQ-017 IDLE: imem_re=0; start & enable -> FETCH, fetch_pc=8'h00; start ignored in other states.
REQ-018 FETCH issue: imem_re=1 with imem_addr=fetch_pc when enable=1, no redirect, and count+inflight<4; fetch_pc increments on issue.
REQ-019 fetch_pc is 8 bits, wraps 8'hFF -> 8'h00.
REQ-020 inflight is a 1-bit flag set on the issue cycle; the next cycle's imem_data is pushed into the queue unless discarded.
REQ-021 Queue: 4-entry FIFO, 2-bit read/write pointers with wrap, count 0..4; push and pop in the same cycle leave count unchanged.
REQ-022 i_datain = head entry when count>0, else NOP_WORD; i_valid = (count>0); both combinational from registers.
REQ-023 Minimum latency: start pulse at cycle 0 -> imem_re at cycle 1 -> i_valid at cycle 3.
REQ-024 A pushed word with [15:11]==HALT_OP -> state HALTED the same edge; responses to requests issued after it are discarded; no further issue.
REQ-025 HALTED: imem_re=0; queue keeps draining; halted = (state==HALTED) & (count==0).
REQ-026 redirect & enable, in FETCH or HALTED: count=0, pointers=0, pending response discarded, fetch_pc=redirect_addr, state FETCH; first new issue on the next cycle.
REQ-027 redirect is ignored in IDLE; redirect has priority over push and pop in the same cycle.
REQ-028 enable=0: imem_re=0, no pop, no state/pc change; a response already in flight is still captured.
REQ-029 Queue full (count=4) blocks issue; a pop from empty never occurs because i_valid gates it.

Reset
REQ-030 reset=1 asynchronously forces: state IDLE, fetch_pc=0, count=0, pointers=0, inflight=0, imem_re=0, imem_addr=0, i_valid=0, i_datain=NOP_WORD, halted=0.
REQ-031 Reset asserted mid-fetch drops all queued and in-flight data; after release, fetching restarts only on a new start pulse.

Verification
REQ-032 Memory words 0x00..0x03 = 16'h1111,2222,3333,HALT(16'h0800); start pulse, i_ready=1 -> CPU receives 1111,2222,3333,0800 on consecutive cycles from cycle 3; halted=1 one cycle after 0800 pops; no imem_re with addr>0x04.
REQ-033 i_ready=0 after start -> exactly 4 requests (addr 00..03), i_valid=1, count=4, imem_re stays 0; raise i_ready -> issue resumes at addr 04.
REQ-034 Redirect to 8'h40 while queue holds 3 entries -> i_valid=0 next cycle, imem_addr=40 with imem_re=1, first valid word = mem[0x40].
REQ-035 redirect_addr=8'hFE, run continuously -> issued addresses FE, FF, 00, 01.
REQ-036 enable=0 for 3 cycles mid-stream -> no pops, no requests, pending response captured; stream resumes unchanged after enable=1.
REQ-037 reset pulse during FETCH with count=2 -> all outputs at reset values immediately; no activity until start.
